// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_pkg
// Description : Shared definitions for the EX-stage multiply/divide unit:
//               op encodings, FSM state type and iteration-counter sizing.
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  // Counter must hold the value WIDTH itself, hence WIDTH+1 codes.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

  localparam int MULDIV_WIDTH = 32;
  localparam int CNT_W        = cnt_width(MULDIV_WIDTH);

endpackage
`default_nettype wire

// File: rtl/ex_muldiv_step.sv
`default_nettype none
// ============================================================================
// Module      : ex_muldiv_step
// Description : One iteration of the multiply/divide datapath. The 2*WIDTH
//               accumulator holds {partial product, multiplier} for multiply
//               and {remainder, dividend/quotient} for divide.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 is_div,
  input  logic [2*WIDTH-1:0]   acc,
  input  logic [WIDTH-1:0]     mcand,
  input  logic [WIDTH-1:0]     divisor,
  output logic [2*WIDTH-1:0]   acc_next
);

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_shifted;
  logic [WIDTH:0] w_diff;

  // Shift-add multiply step or restoring subtract-shift divide step.
  always_comb begin
    w_sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
    w_shifted = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    w_diff    = w_shifted - {1'b0, divisor};
    acc_next  = {w_sum, acc[WIDTH-1:1]};
    if (is_div) begin
      // Remainder stays below the divisor, so a set top bit means borrow.
      if (!w_diff[WIDTH]) begin
        acc_next = {w_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = {w_shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ex_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : ex_muldiv
// Description : Iterative MULT/MULTU/DIV/DIVU unit for the EX stage. Works on
//               magnitudes for WIDTH cycles, then sign-corrects and commits
//               HI/LO. Holds stall_req while busy.
//               Optional: MULDIV_DIV0_FLAG_EN adds a sticky div_by_zero flag.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_muldiv
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             flush,
  output logic             busy,
  output logic             stall_req,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
`ifdef MULDIV_DIV0_FLAG_EN
  ,
  output logic             div_by_zero
`endif
);

  localparam int ITER_W = cnt_width(WIDTH);

  state_t              r_state;
  state_t              w_next;
  logic [ITER_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0]  r_acc;
  logic [2*WIDTH-1:0]  w_acc_next;
  logic [WIDTH-1:0]    r_mag_a;
  logic [WIDTH-1:0]    r_mag_b;
  logic                r_is_div;
  logic                r_neg_lo;
  logic                r_neg_hi;
  logic                r_b_zero;
  logic [WIDTH-1:0]    r_hi;
  logic [WIDTH-1:0]    r_lo;
  logic                r_done;

  logic                w_accept;
  logic                w_is_div;
  logic                w_sa;
  logic                w_sb;
  logic [WIDTH-1:0]    w_mag_a;
  logic [WIDTH-1:0]    w_mag_b;
  logic [2*WIDTH-1:0]  w_prod;
  logic [WIDTH-1:0]    w_quo;
  logic [WIDTH-1:0]    w_rem;
  logic [WIDTH-1:0]    w_hi_res;
  logic [WIDTH-1:0]    w_lo_res;
  logic                w_busy;

  // Operand decode: signs count only for the signed ops (op[0]==0).
  always_comb begin
    w_accept = (r_state == IDLE) && start && !flush;
    w_is_div = (op == OP_DIV) || (op == OP_DIVU);
    w_sa     = operand_a[WIDTH-1] & ~op[0];
    w_sb     = operand_b[WIDTH-1] & ~op[0];
    w_mag_a  = w_sa ? -operand_a : operand_a;
    w_mag_b  = w_sb ? -operand_b : operand_b;
  end

  ex_muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div   (r_is_div),
    .acc      (r_acc),
    .mcand    (r_mag_a),
    .divisor  (r_mag_b),
    .acc_next (w_acc_next)
  );

  // Sign correction of the finished magnitudes. For a zero divisor the
  // remainder equals |a| and re-applying a's sign restores operand_a.
  always_comb begin
    w_prod   = r_neg_lo ? -r_acc : r_acc;
    w_quo    = r_neg_lo ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    w_rem    = r_neg_hi ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
    w_hi_res = w_prod[2*WIDTH-1:WIDTH];
    w_lo_res = w_prod[WIDTH-1:0];
    if (r_is_div) begin
      w_hi_res = w_rem;
      w_lo_res = r_b_zero ? '1 : w_quo;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic; flush beats the FIX commit.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = CALC;
      CALC:    if (flush) w_next = IDLE;
               else if (r_cnt == ITER_W'(1)) w_next = FIX;
      FIX:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    w_busy    = (r_state != IDLE);
    busy      = w_busy;
    stall_req = w_busy;
    done      = r_done;
    hi        = r_hi;
    lo        = r_lo;
  end

  // Operand latch, iteration datapath and HI/LO commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mag_a  <= '0;
      r_mag_b  <= '0;
      r_is_div <= 1'b0;
      r_neg_lo <= 1'b0;
      r_neg_hi <= 1'b0;
      r_b_zero <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (w_accept) begin
          r_is_div <= w_is_div;
          r_mag_a  <= w_mag_a;
          r_mag_b  <= w_mag_b;
          r_neg_lo <= w_sa ^ w_sb;
          r_neg_hi <= w_sa;
          r_b_zero <= (operand_b == '0);
          r_cnt    <= ITER_W'(WIDTH);
          r_acc    <= w_is_div ? {{WIDTH{1'b0}}, w_mag_a} : {{WIDTH{1'b0}}, w_mag_b};
        end
        CALC: if (!flush) begin
          r_acc <= w_acc_next;
          r_cnt <= r_cnt - ITER_W'(1);
        end
        FIX: if (!flush) begin
          r_hi   <= w_hi_res;
          r_lo   <= w_lo_res;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef MULDIV_DIV0_FLAG_EN
  logic r_dbz;

  // Sticky divide-by-zero flag, cleared when the next op is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dbz <= 1'b0;
    end else if (w_accept) begin
      r_dbz <= 1'b0;
    end else if ((r_state == FIX) && !flush && r_is_div && r_b_zero) begin
      r_dbz <= 1'b1;
    end
  end

  assign div_by_zero = r_dbz;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_muldiv
// Description : Directed self-checking bench for ex_muldiv (WIDTH=32).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_muldiv;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        flush;
  logic        busy;
  logic        stall_req;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
`ifdef MULDIV_DIV0_FLAG_EN
  logic        div_by_zero;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int edges;
  int busy_hi;
  int done_seen;

  ex_muldiv #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .op          (op),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .flush       (flush),
    .busy        (busy),
    .stall_req   (stall_req),
    .done        (done),
    .hi          (hi),
    .lo          (lo)
`ifdef MULDIV_DIV0_FLAG_EN
    ,
    .div_by_zero (div_by_zero)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an op for one edge (E0).
  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    start     = 1'b1;
    op        = o;
    operand_a = a;
    operand_b = b;
    tick();
    start = 1'b0;
  endtask

  // Wait for done; reports edges after E0 and cycles busy was seen high.
  task automatic wait_done(output int n_edges, output int n_busy);
    n_edges = 0;
    n_busy  = busy ? 1 : 0;
    while (done !== 1'b1 && n_edges < 60) begin
      tick();
      n_edges++;
      if (busy) n_busy++;
    end
    check("no_timeout", {63'd0, (n_edges < 60)}, 64'd1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 2'b00; operand_a = '0; operand_b = '0; flush = 1'b0;
    #12;
    check("rst_busy",  {63'd0, busy},      64'd0);
    check("rst_stall", {63'd0, stall_req}, 64'd0);
    check("rst_done",  {63'd0, done},      64'd0);
    check("rst_hi",    {32'd0, hi},        64'd0);
    check("rst_lo",    {32'd0, lo},        64'd0);
    rst = 1'b0;
    tick();

    // MULTU max*max: 33-edge latency, 33 busy cycles.
    launch(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu_busy_e0", {63'd0, busy}, 64'd1);
    wait_done(edges, busy_hi);
    check("multu_latency", 64'(edges),   64'd33);
    check("multu_busy_cy", 64'(busy_hi), 64'd33);
    check("multu_hi", {32'd0, hi}, 64'h0000_0000_FFFF_FFFE);
    check("multu_lo", {32'd0, lo}, 64'h0000_0000_0000_0001);
    tick();
    check("done_pulse_clears", {63'd0, done}, 64'd0);
    check("busy_after_done",   {63'd0, busy}, 64'd0);

    // MULT -3*7, then back-to-back DIV -7/2.
    launch(OP_MULT, 32'hFFFF_FFFD, 32'h0000_0007);
    wait_done(edges, busy_hi);
    check("mult_hi", {32'd0, hi}, 64'h0000_0000_FFFF_FFFF);
    check("mult_lo", {32'd0, lo}, 64'h0000_0000_FFFF_FFEB);
    launch(OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002);
    check("b2b_accepted", {63'd0, busy}, 64'd1);
    wait_done(edges, busy_hi);
    check("div_neg_lo", {32'd0, lo}, 64'h0000_0000_FFFF_FFFD);
    check("div_neg_hi", {32'd0, hi}, 64'h0000_0000_FFFF_FFFF);

    // DIVU 100/7.
    launch(OP_DIVU, 32'd100, 32'd7);
    wait_done(edges, busy_hi);
    check("divu_lo", {32'd0, lo}, 64'd14);
    check("divu_hi", {32'd0, hi}, 64'd2);

    // Signed overflow.
    launch(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(edges, busy_hi);
    check("div_ovf_lo", {32'd0, lo}, 64'h0000_0000_8000_0000);
    check("div_ovf_hi", {32'd0, hi}, 64'd0);

    // Divide by zero, unsigned then signed.
    launch(OP_DIVU, 32'd100, 32'd0);
    wait_done(edges, busy_hi);
    check("divu0_lo", {32'd0, lo}, 64'h0000_0000_FFFF_FFFF);
    check("divu0_hi", {32'd0, hi}, 64'h0000_0000_0000_0064);
`ifdef MULDIV_DIV0_FLAG_EN
    check("dbz_set", {63'd0, div_by_zero}, 64'd1);
`endif
    launch(OP_DIV, 32'hFFFF_FFF9, 32'd0);
`ifdef MULDIV_DIV0_FLAG_EN
    check("dbz_cleared_on_start", {63'd0, div_by_zero}, 64'd0);
`endif
    wait_done(edges, busy_hi);
    check("div0_lo", {32'd0, lo}, 64'h0000_0000_FFFF_FFFF);
    check("div0_hi", {32'd0, hi}, 64'h0000_0000_FFFF_FFF9);

    // Preload hi=0x11, lo=0x22 via DIVU 0x451/0x20.
    launch(OP_DIVU, 32'h0000_0451, 32'h0000_0020);
    wait_done(edges, busy_hi);
    check("preload_hi", {32'd0, hi}, 64'h11);
    check("preload_lo", {32'd0, lo}, 64'h22);
`ifdef MULDIV_DIV0_FLAG_EN
    check("dbz_clear_after_div", {63'd0, div_by_zero}, 64'd0);
`endif

    // Flush mid-CALC: raised after E10, taken at E11.
    launch(OP_MULTU, 32'd5, 32'd6);
    for (int i = 0; i < 10; i++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_busy", {63'd0, busy}, 64'd0);
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) done_seen++;
    end
    check("flush_no_done", 64'(done_seen), 64'd0);
    check("flush_hi", {32'd0, hi}, 64'h11);
    check("flush_lo", {32'd0, lo}, 64'h22);

    // start together with flush in IDLE is ignored.
    start = 1'b1; flush = 1'b1; op = OP_MULTU; operand_a = 32'd2; operand_b = 32'd2;
    tick();
    start = 1'b0; flush = 1'b0;
    check("idle_flush_start_busy", {63'd0, busy}, 64'd0);
    tick();
    check("idle_flush_start_busy2", {63'd0, busy}, 64'd0);
    check("idle_flush_hi", {32'd0, hi}, 64'h11);

    // Asynchronous reset mid-CALC.
    launch(OP_MULTU, 32'd3, 32'd4);
    for (int i = 0; i < 5; i++) tick();
    #2 rst = 1'b1;
    #1;
    check("arst_busy",  {63'd0, busy},      64'd0);
    check("arst_stall", {63'd0, stall_req}, 64'd0);
    check("arst_done",  {63'd0, done},      64'd0);
    check("arst_hi",    {32'd0, hi},        64'd0);
    check("arst_lo",    {32'd0, lo},        64'd0);
    rst = 1'b0;
    tick();
    launch(OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(edges, busy_hi);
    check("post_rst_latency", 64'(edges), 64'd33);
    check("post_rst_hi", {32'd0, hi}, 64'd0);
    check("post_rst_lo", {32'd0, lo}, 64'd1);

    // start while busy is ignored.
    launch(OP_MULTU, 32'h0001_0000, 32'h0001_0000);
    for (int i = 0; i < 3; i++) tick();
    start = 1'b1; op = OP_DIVU; operand_a = 32'd9; operand_b = 32'd3;
    tick();
    start = 1'b0;
    wait_done(edges, busy_hi);
    check("busy_start_hi", {32'd0, hi}, 64'd1);
    check("busy_start_lo", {32'd0, lo}, 64'd0);
    tick();
    check("busy_start_no_queue", {63'd0, busy}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
- Iterative multiply/divide unit in the EX stage.
- Consumes operand/op fields delivered by the ID/EX pipeline register.
- Computes MULT/MULTU/DIV/DIVU into architectural HI/LO registers over multiple cycles.
- Raises a stall request to the hazard logic while busy, so ID/EX and earlier stages hold and HI/LO readers wait.

Parameters:
WIDTH, 32, operand width; iteration count equals WIDTH

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-high
start  input  1  launch request; sampled only in IDLE
op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
operand_a  input  WIDTH  multiplicand / dividend
operand_b  input  WIDTH  multiplier / divisor
flush  input  1  abort in-flight operation
busy  output  1  state != IDLE
stall_req  output  1  equals busy
done  output  1  one-cycle pulse; hi/lo valid that cycle
hi  output  WIDTH  HI register (product high / remainder)
lo  output  WIDTH  LO register (product low / quotient)
div_by_zero  output  1  only with MULDIV_DIV0_FLAG_EN

Behaviour:
- Clock is clk; reset is rst, asynchronous, active-high.
- Reset (any time, including mid-operation): state IDLE, hi=0, lo=0, done=0, counter=0, internal accumulators=0. busy and stall_req go low immediately.
- FSM states: IDLE, CALC, FIX.
- IDLE, on start=1 and flush=0:
  - Latch op and signedness.
  - Latch magnitudes |a| and |b|; signed ops only (op[0]=0).
  - Latch result signs:
    - Multiply: product sign = sa^sb.
    - Divide: quotient sign = sa^sb; remainder sign = sa.
  - Latch b_zero = (operand_b==0).
  - counter <= WIDTH; go to CALC.
- IDLE, start=0: remain. IDLE, start=1 with flush=1: start ignored.
- CALC: one iteration per edge.
  - Multiply: shift-add over a 2*WIDTH accumulator.
  - Divide: one restoring subtract-shift step.
  - counter decrements. On the edge where counter reaches 0, go to FIX.
- FIX, one edge:
  - Apply sign correction (two's-complement negate of magnitude where required).
  - Write hi/lo, set done=1, go to IDLE.
  - done auto-clears on the next edge.
- Latency: start sampled at edge E0; WIDTH iterations on E1..E_WIDTH; results and done visible after E_(WIDTH+1). For WIDTH=32 this is 33 edges; stall_req is high for exactly 33 cycles.
- start while busy: ignored; no queueing.
- flush in CALC or FIX: go to IDLE next edge; hi/lo unchanged; done stays 0.
- flush in IDLE: no effect.
- flush has priority over FIX commit on the same edge.
- Divide by zero (b_zero): lo = all ones, hi = operand_a as latched. Applies to both signed and unsigned; no exception raised.
- Signed overflow (DIV 0x80000000 / 0xFFFFFFFF): lo=0x80000000, hi=0. This is the natural result of the magnitude arithmetic mod 2^WIDTH.
- Multiply results: hi:lo = full 2*WIDTH product.
- Divide results: lo=quotient, hi=remainder, truncation toward zero.
- hi/lo change only on FIX commit or reset.

Optional Feature:
- Macro MULDIV_DIV0_FLAG_EN.
- Defined:
  - div_by_zero port exists.
  - Set to 1 on the FIX commit of a DIV/DIVU with b_zero.
  - Cleared on the next start accepted in IDLE, or by reset.
  - Unchanged by flush.
- Undefined: port and logic absent; results identical.

Decomposition:
- Package muldiv_pkg:
  - op encodings OP_MULT, OP_MULTU, OP_DIV, OP_DIVU.
  - FSM state enum (IDLE, CALC, FIX).
  - Iteration-counter width constant clog2(WIDTH+1).
- One natural sub-module: ex_muldiv_step.
  - Combinational single-iteration datapath.
  - Given op class and current accumulator/remainder/quotient, returns next values.
  - Instantiated once inside ex_muldiv's CALC datapath.

Test Plan:
- MULTU 0xFFFFFFFF*0xFFFFFFFF, start at E0 -> done pulses after E33 only, hi=0xFFFFFFFE, lo=0x00000001; busy high 33 cycles then low.
- MULT -3*7 (0xFFFFFFFD, 0x00000007) -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Follow with back-to-back start on the cycle after done -> accepted.
- DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/7 -> lo=14, hi=2. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU 100/0 -> lo=0xFFFFFFFF, hi=0x00000064. With MULDIV_DIV0_FLAG_EN: div_by_zero=1 after commit, cleared on the next accepted start.
- Preload hi=0x11, lo=0x22; start MULTU 5*6; flush at E10 -> busy low after E11, done never pulses, hi/lo remain 0x11/0x22. start with flush same cycle in IDLE -> ignored.
- rst asserted asynchronously mid-CALC (between edges) -> busy, stall_req, done, hi, lo drop to 0 immediately; after release a new start completes normally. start pulses while busy -> ignored, result matches the first op.
